// File: rtl/router_out_fifo.sv
// Per-destination output FIFO. Header bytes are tagged on write so the read
// side can track packet boundaries and report when a packet is fully drained.
module router_out_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_busy
);

  localparam int CNT_W = 6;

  typedef struct packed {
    logic             hdr;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [ADDR:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             do_wr, do_rd;
  entry_t           rd_entry;
  logic [CNT_W-1:0] hdr_len;

  // Extra pointer MSB distinguishes full from empty when addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR-1:0] == rd_ptr[ADDR-1:0]) &&
                 (wr_ptr[ADDR] != rd_ptr[ADDR]);

  // Soft reset wins over both ports; flags are sampled before the edge.
  assign do_wr = write_enb && !full  && !soft_reset;
  assign do_rd = read_enb  && !empty && !soft_reset;

  assign rd_entry = mem[rd_ptr[ADDR-1:0]];
  // Payload length lives in the upper six bits of the header byte.
  assign hdr_len  = rd_entry.data[WIDTH-1 -: CNT_W];

  always_comb begin
    cnt_nxt = cnt;
    if (do_rd) begin
      if (rd_entry.hdr)
        cnt_nxt = hdr_len + CNT_W'(1);
      else if (cnt != '0)
        cnt_nxt = cnt - CNT_W'(1);
    end
  end

  // Storage has no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (do_wr)
      mem[wr_ptr[ADDR-1:0]] <= '{hdr: lfd_state, data: data_in};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      pkt_busy <= 1'b0;
      data_out <= '0;
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      pkt_busy <= 1'b0;
      data_out <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_entry.data;
      end
      cnt      <= cnt_nxt;
      pkt_busy <= (cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_router_out_fifo.sv
// Directed self-checking bench for router_out_fifo.
module tb_router_out_fifo;

  logic       clock = 1'b0;
  logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       full, empty, pkt_busy;

  int n_tests = 0;
  int n_fail  = 0;

  router_out_fifo #(.DEPTH(16), .WIDTH(8), .ADDR(4)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .pkt_busy(pkt_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1; data_in = d; lfd_state = hdr;
    step();
    write_enb = 1'b0; lfd_state = 1'b0;
  endtask

  task automatic rd();
    read_enb = 1'b1;
    step();
    read_enb = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] pkt [5];
  logic       busy_exp [5];

  initial begin
    resetn = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;

    // 1: asynchronous reset asserted mid-cycle
    @(posedge clock); #3;
    resetn = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_dout",  32'(data_out), 32'h00);
    chk("rst_busy",  32'(pkt_busy), 0);
    step();
    resetn = 1'b1;
    step();

    // 2: single packet, header 0D -> 3 payload + parity
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h2D};
    busy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    wr(pkt[0], 1'b1);
    for (int i = 1; i < 5; i++) wr(pkt[i], 1'b0);
    chk("pkt_notempty", 32'(empty), 0);
    read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("pkt_dout%0d", i), 32'(data_out), 32'(pkt[i]));
      chk($sformatf("pkt_busy%0d", i), 32'(pkt_busy), 32'(busy_exp[i]));
    end
    read_enb = 1'b0;
    chk("pkt_empty", 32'(empty), 1);

    // 3: fill and overflow
    for (int i = 0; i < 17; i++) begin
      wr(8'(i), 1'b0);
      if (i == 14) chk("fill_nfull15", 32'(full), 0);
      if (i == 15) chk("fill_full16", 32'(full), 1);
    end
    chk("fill_full17", 32'(full), 1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk($sformatf("fill_rd%0d", i), 32'(data_out), 32'(i));
    end
    chk("fill_empty", 32'(empty), 1);

    // 4a: simultaneous read/write while full
    for (int i = 0; i < 16; i++) wr(8'hA0 + 8'(i), 1'b0);
    chk("sim_full", 32'(full), 1);
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'hFF;
    step();
    read_enb = 1'b0; write_enb = 1'b0;
    chk("simf_dout", 32'(data_out), 32'hA0);
    chk("simf_nfull", 32'(full), 0);
    for (int i = 1; i < 16; i++) begin
      rd();
      chk($sformatf("simf_rd%0d", i), 32'(data_out), 32'(8'hA0 + 8'(i)));
    end
    chk("simf_empty", 32'(empty), 1);

    // 4b: simultaneous read/write while empty, no bypass
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h55;
    step();
    read_enb = 1'b0; write_enb = 1'b0;
    chk("sime_dout", 32'(data_out), 32'hAF);
    chk("sime_nempty", 32'(empty), 0);
    rd();
    chk("sime_rd", 32'(data_out), 32'h55);
    chk("sime_empty", 32'(empty), 1);

    // 5: 40-byte stream across pointer wrap, occupancy held at 8
    for (int i = 0; i < 8; i++) begin
      wr(8'h40 + 8'(i), 1'b0);
      q.push_back(8'h40 + 8'(i));
    end
    for (int i = 8; i < 40; i++) begin
      read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h40 + 8'(i);
      q.push_back(8'h40 + 8'(i));
      step();
      chk($sformatf("wrap_d%0d", i), 32'(data_out), 32'(q.pop_front()));
      chk($sformatf("wrap_f%0d", i), {31'd0, full | empty}, 0);
    end
    read_enb = 1'b0; write_enb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd();
      chk($sformatf("wrap_tail%0d", i), 32'(data_out), 32'(q.pop_front()));
    end
    chk("wrap_empty", 32'(empty), 1);

    // 6: soft reset mid-packet with a concurrent write
    wr(8'h14, 1'b1);
    for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i), 1'b0);
    rd(); rd(); rd();
    chk("srst_pre_busy", 32'(pkt_busy), 1);
    chk("srst_pre_dout", 32'(data_out), 32'h61);
    soft_reset = 1'b1; write_enb = 1'b1; data_in = 8'h77;
    step();
    soft_reset = 1'b0; write_enb = 1'b0;
    chk("srst_empty", 32'(empty), 1);
    chk("srst_busy",  32'(pkt_busy), 0);
    chk("srst_dout",  32'(data_out), 32'h00);
    // stray untagged byte keeps counter at zero; write dropped above
    wr(8'h3C, 1'b0);
    rd();
    chk("stray_dout", 32'(data_out), 32'h3C);
    chk("stray_busy", 32'(pkt_busy), 0);
    // zero-length header leaves only the parity pending
    wr(8'h01, 1'b1);
    wr(8'h9E, 1'b0);
    rd();
    chk("len0_busy", 32'(pkt_busy), 1);
    rd();
    chk("len0_par", 32'(data_out), 32'h9E);
    chk("len0_done", 32'(pkt_busy), 0);

    // async reset with data present
    wr(8'hC3, 1'b1);
    rd();
    wr(8'h12, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    chk("rst2_empty", 32'(empty), 1);
    chk("rst2_busy",  32'(pkt_busy), 0);
    chk("rst2_dout",  32'(data_out), 32'h00);
    step();
    resetn = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_out_fifo.md
Name: router_out_fifo

Overview:
- Per-destination output FIFO directly downstream of the router register stage. Three instances exist, one per output port.
- Stores the byte stream produced by the register stage (header, payload, parity) and tags each stored header so the read side can track packet boundaries.
- A read-side byte counter reports when the current packet has been completely drained.
- Supports a synchronous soft reset driven by the port-timeout logic.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, minimum 4.
- WIDTH, 8, data byte width.
- ADDR, 4, log2(DEPTH).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- soft_reset  in  1  synchronous flush, active high.
- write_enb  in  1  write request from the synchroniser for this port.
- read_enb  in  1  read request from the destination.
- lfd_state  in  1  high during the cycle the header byte is written.
- data_in  in  WIDTH  byte from the register stage (dout).
- data_out  out  WIDTH  registered read data.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- pkt_busy  out  1  a packet is partially read; payload and/or parity bytes are still pending on the read side.

Behaviour:
- Storage: DEPTH entries of WIDTH+1 bits; bit WIDTH is the header tag.
- Pointers: wr_ptr and rd_ptr are ADDR+1 bits wide, with wrap via the MSB.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal) and (MSBs differ).
  - full and empty are combinational from the pointers.
- Reset (resetn low, asynchronous):
  - pointers = 0, byte counter = 0;
  - data_out = 0, pkt_busy = 0;
  - empty = 1, full = 0.
  - Memory contents are don't-care.
- Soft reset (soft_reset high at a clock edge):
  - Same clearing as reset, synchronous to the edge.
  - Takes priority over read and write in that cycle; any write in that cycle is dropped.
- Write: when write_enb && !full, mem[wr_ptr] = {lfd_state, data_in} and wr_ptr increments. A write while full is ignored, with no pointer change.
- Read: when read_enb && !empty, data_out <= mem[rd_ptr][WIDTH-1:0] and rd_ptr increments.
  - Latency: one clock from the read_enb edge to data_out valid.
  - data_out holds its value when no read occurs.
  - A read while empty is ignored.
- Simultaneous read and write:
  - Both are evaluated against the pre-edge full/empty flags.
  - When full, only the read occurs (the write is dropped).
  - When empty, only the write occurs; there is no bypass.
  - Otherwise both occur and the occupancy is unchanged.
- Byte counter (6 bits):
  - On a read of a tagged (header) entry: counter = data[7:2] + 1, i.e. payload length plus the parity byte.
  - On a read of an untagged entry with counter > 0: counter decrements.
  - pkt_busy = (counter != 0), registered alongside the counter.
  - A header read with data[7:2] = 0 loads 1, so only the parity byte is pending.
  - An untagged read with counter = 0 (a stray byte) leaves the counter at 0.
- Occupancy: entries = wr_ptr - rd_ptr, modulo 2^(ADDR+1). Pointer wrap is seamless across the DEPTH boundary.

Test Plan:
1. Reset then idle:
   - Stimulus: assert resetn=0 mid-cycle.
   - Required: empty=1, full=0, data_out=8'h00, pkt_busy=0 immediately, before the next edge.
2. Single packet:
   - Stimulus: write header 8'h0D (length 3) with lfd_state=1, then payload 8'h11, 8'h22, 8'h33, then parity 8'h2D. Then read 5 bytes back to back.
   - Required: data_out sequence 0D, 11, 22, 33, 2D, each one cycle after its read. pkt_busy=1 after the header read, counts 4, 3, 2, 1, and reaches 0 after the parity read. empty=1 at the end.
3. Fill and overflow:
   - Stimulus: write 17 bytes 8'h00..8'h10 with no reads.
   - Required: full=1 after the 16th write; the 17th write is dropped. Reading 16 bytes returns 00..0F, and empty=1 afterwards.
4. Simultaneous read and write:
   - Full case: assert both while full. Required: one read returns the oldest byte; full deasserts; the write is lost.
   - Empty case: assert both while empty. Required: the write is stored; data_out is unchanged; empty=0 next cycle.
5. Pointer wrap:
   - Stimulus: stream 40 bytes with interleaved reads, keeping occupancy between 1 and 15.
   - Required: output order matches input order exactly; full and empty are never falsely asserted.
6. Soft reset mid-packet:
   - Stimulus: after the header and 2 payload bytes have been read (pkt_busy=1), pulse soft_reset for one cycle while write_enb=1.
   - Required: next cycle empty=1, pkt_busy=0, data_out=8'h00; the concurrent write is not stored.
